// File: rtl/sbox_arbiter.sv
// Two-requester arbiter in front of a shared, fixed-latency composite S-box.
// Optional build macro SBOX_ARB_FIXED_PRIO_EN: key-schedule requester wins all contention.
module sbox_arbiter #(
    parameter int SBOX_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_encrypt,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_encrypt,
    output logic        req1_ready,

    output logic        sbox_in_valid,
    output logic [7:0]  sbox_in,
    output logic        sbox_encrypt,
    input  logic [7:0]  sbox_out,

    output logic        rsp0_valid,
    output logic [7:0]  rsp0_data,
    output logic        rsp1_valid,
    output logic [7:0]  rsp1_data,

    output logic [15:0] stall_cnt
);

    localparam int DATA_W = 8;

    logic                last_grant_q, last_grant_d;
    logic [15:0]         stall_q, stall_d;
    logic [SBOX_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [SBOX_LAT-1:0] tag_id_q, tag_id_d;

    logic                grant;
    logic                pick1;
    logic                lost;
    logic                tail_vld;
    logic                tail_id;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Arbitration: pick1 selects requester 1 when a grant happens.
    always_comb begin
`ifdef SBOX_ARB_FIXED_PRIO_EN
        pick1 = req1_valid;
`else
        pick1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif
        grant      = ~rst & (req0_valid | req1_valid);
        req0_ready = grant & ~pick1;
        req1_ready = grant & pick1;
    end

    always_comb begin
        sbox_in_valid = grant;
        sbox_in       = {DATA_W{1'b0}};
        sbox_encrypt  = 1'b1;
        if (grant) begin
            sbox_in      = pick1 ? req1_data    : req0_data;
            sbox_encrypt = pick1 ? req1_encrypt : req0_encrypt;
        end
    end

    // Tag pipeline stage 0 captures the grant; the tail lines up with sbox_out.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = grant;
        tag_id_d[0]  = pick1;
        for (int i = 1; i < SBOX_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_comb begin
        lost         = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);
        stall_d      = lost ? sat_inc16(stall_q) : stall_q;
        last_grant_d = grant ? pick1 : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q    <= '0;
            last_grant_q <= 1'b1;
            stall_q      <= 16'h0000;
        end else begin
            tag_vld_q    <= tag_vld_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
        end
    end

    // Requester id is qualified by tag_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

    // Response stage: steer the S-box result to the requester that launched it.
    always_comb begin
        tail_vld   = ~rst & tag_vld_q[SBOX_LAT-1];
        tail_id    = tag_id_q[SBOX_LAT-1];
        rsp0_valid = tail_vld & ~tail_id;
        rsp1_valid = tail_vld & tail_id;
        rsp0_data  = rsp0_valid ? sbox_out : {DATA_W{1'b0}};
        rsp1_data  = rsp1_valid ? sbox_out : {DATA_W{1'b0}};
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Randomized bench for sbox_arbiter with a cycle-indexed expectation model.
// Honours SBOX_ARB_FIXED_PRIO_EN when compiled together with the RTL.
module tb_sbox_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_encrypt, req0_ready;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_encrypt, req1_ready;
    logic [7:0]  req1_data;
    logic        sbox_in_valid, sbox_encrypt;
    logic [7:0]  sbox_in, sbox_out;
    logic        rsp0_valid, rsp1_valid;
    logic [7:0]  rsp0_data, rsp1_data;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sbox_arbiter #(.SBOX_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_encrypt(req0_encrypt), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_encrypt(req1_encrypt), .req1_ready(req1_ready),
        .sbox_in_valid(sbox_in_valid), .sbox_in(sbox_in), .sbox_encrypt(sbox_encrypt), .sbox_out(sbox_out),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .stall_cnt(stall_cnt)
    );

    // Stand-in S-box: a reversible byte map, 53/enc -> ED.
    function automatic logic [7:0] sb(input logic [7:0] x, input logic enc);
        return enc ? (x ^ 8'hBE) : (x ^ 8'h5A);
    endfunction

    logic [7:0] sdl [LAT];
    initial for (int i = 0; i < LAT; i++) sdl[i] = 8'h00;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) sdl[i] <= sdl[i-1];
        sdl[0] <= sbox_in_valid ? sb(sbox_in, sbox_encrypt) : 8'h00;
    end
    assign sbox_out = sdl[LAT-1];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: expected responses stored by the cycle in which they must appear.
    int   cyc = 0;
    bit   ev [16];
    bit   eid [16];
    logic [7:0] ed [16];
    bit   m_last = 1'b1;
    int   m_stall = 0;

    always @(negedge clk) begin
        int   slot, s2;
        bit   g, gid, both;
        logic [7:0] gdata;
        logic genc;
        slot = cyc % 16;
        if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_siv", sbox_in_valid, 0);
            chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}, 0);
            for (int i = 0; i < 16; i++) ev[i] = 1'b0;
            m_last  = 1'b1;
            m_stall = 0;
        end else begin
            both = req0_valid && req1_valid;
            g    = req0_valid || req1_valid;
`ifdef SBOX_ARB_FIXED_PRIO_EN
            gid = both ? 1'b1 : req1_valid;
`else
            gid = both ? !m_last : req1_valid;
`endif
            gdata = gid ? req1_data : req0_data;
            genc  = gid ? req1_encrypt : req0_encrypt;
            chk("ready0", req0_ready, g && !gid);
            chk("ready1", req1_ready, g && gid);
            chk("sbox_in_valid", sbox_in_valid, g);
            chk("sbox_in", sbox_in, g ? gdata : 8'h00);
            chk("sbox_encrypt", sbox_encrypt, g ? genc : 1'b1);
            chk("rsp0_valid", rsp0_valid, ev[slot] && !eid[slot]);
            chk("rsp1_valid", rsp1_valid, ev[slot] && eid[slot]);
            chk("rsp0_data", rsp0_data, (ev[slot] && !eid[slot]) ? ed[slot] : 8'h00);
            chk("rsp1_data", rsp1_data, (ev[slot] && eid[slot]) ? ed[slot] : 8'h00);
            chk("stall_cnt", stall_cnt, m_stall);
            ev[slot] = 1'b0;
            if (g) begin
                s2 = (cyc + LAT) % 16;
                ev[s2]  = 1'b1;
                eid[s2] = gid;
                ed[s2]  = sb(gdata, genc);
                m_last  = gid;
            end
            if (both && m_stall < 65535) m_stall++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_data = 8'h00; req0_encrypt = 1;
        req1_valid = 0; req1_data = 8'h00; req1_encrypt = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        repeat (3) tick();
        rst = 0;

        // Single request, latency pinned by literal values.
        do_reset();
        req0_valid = 1; req0_data = 8'h53; req0_encrypt = 1;
        @(negedge clk);
        chk("lit_ready0", req0_ready, 1);
        chk("lit_sbox_in", sbox_in, 8'h53);
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) chk("lit_idle_sbox", {sbox_in_valid, sbox_in, sbox_encrypt}, {1'b0, 8'h00, 1'b1});
            if (k < 3) chk("lit_rsp0_early", rsp0_valid, 0);
            else begin
                chk("lit_rsp0_valid", rsp0_valid, 1);
                chk("lit_rsp0_data", rsp0_data, 8'hED);
            end
            tick();
        end

        // Contention after reset.
        do_reset();
        req0_valid = 1; req0_data = 8'h00; req0_encrypt = 1;
        req1_valid = 1; req1_data = 8'hFF; req1_encrypt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) idle_inputs();
            if (k == 3) begin
                req1_valid = 0;
`ifdef SBOX_ARB_FIXED_PRIO_EN
                @(negedge clk);
                chk("lit_fp_ready0_k3", req0_ready, 1);
                tick();
                continue;
`else
                req1_valid = 1;
`endif
            end
            @(negedge clk);
`ifdef SBOX_ARB_FIXED_PRIO_EN
            if (k < 3) chk("lit_fp_ready1", req1_ready, 1);
            if (k < 3) chk("lit_fp_ready0", req0_ready, 0);
`else
            if (k < 4) chk("lit_rr_ready0", req0_ready, (k % 2) == 0);
            if (k < 4) chk("lit_rr_ready1", req1_ready, (k % 2) == 1);
            if (k >= 3 && k < 7) chk("lit_rr_rsp0", rsp0_valid, ((k - 3) % 2) == 0);
            if (k >= 3 && k < 7) chk("lit_rr_rsp1", rsp1_valid, ((k - 3) % 2) == 1);
            if (k == 3) chk("lit_rr_rsp0_data", rsp0_data, 8'hBE);
            if (k == 4) chk("lit_rr_rsp1_data", rsp1_data, 8'hA5);
            if (k == 4) chk("lit_rr_stall", stall_cnt, 4);
`endif
            tick();
        end

        // Reset while two results are in flight.
        do_reset();
        req0_valid = 1; req0_data = 8'h11;
        tick();
        req0_valid = 0; req1_valid = 1; req1_data = 8'h22;
        tick();
        req1_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("lit_flush_rsp", {rsp0_valid, rsp1_valid}, 0);
            chk("lit_flush_stall", stall_cnt, 0);
            tick();
        end

        // Saturation of the stall counter under sustained contention.
        do_reset();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 65540; i++) begin
            req0_data = 8'($urandom); req1_data = 8'($urandom);
            @(negedge clk);
            if (i == 65534) chk("lit_stall_fffe", stall_cnt, 16'hFFFE);
            if (i == 65535) chk("lit_stall_ffff", stall_cnt, 16'hFFFF);
            tick();
        end
        @(negedge clk);
        chk("lit_stall_hold", stall_cnt, 16'hFFFF);
        tick();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            req0_valid   = ($urandom_range(0, 99) < 60);
            req1_valid   = ($urandom_range(0, 99) < 55);
            req0_data    = 8'($urandom);
            req1_data    = 8'($urandom);
            req0_encrypt = 1'($urandom);
            req1_encrypt = 1'($urandom);
            tick();
        end
        rst = 0;
        idle_inputs();
        repeat (LAT + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_arbiter.md
SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 3: fixed pipeline latency, in cycles, of the shared composite S-box (pre-processing, GF(2^8) inversion, post-processing); legal range 1..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req0_valid  input  1  state-datapath (SubBytes) request valid.
REQ-005 SHALL have port req0_data  input  8  byte to substitute.
REQ-006 SHALL have port req0_encrypt  input  1  1 = forward S-box, 0 = inverse S-box.
REQ-007 SHALL have port req0_ready  output  1  request 0 accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_data, req1_encrypt and req1_ready, with the same widths and meanings as REQ-004..REQ-007, for the key-schedule requester.
REQ-009 SHALL have port sbox_in_valid  output  1  byte launched into the shared S-box this cycle.
REQ-010 SHALL have port sbox_in  output  8  byte to the S-box.
REQ-011 SHALL have port sbox_encrypt  output  1  mode to the S-box.
REQ-012 SHALL have port sbox_out  input  8  S-box result, valid exactly SBOX_LAT cycles after launch.
REQ-013 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle result pulse per requester; no backpressure.
REQ-014 SHALL have ports rsp0_data/rsp1_data  output  8  result byte.
REQ-015 SHALL have port stall_cnt  output  16  saturating count of lost-arbitration cycles.

Function
REQ-016 SHALL grant at most one requester per cycle; reqN_ready = 1 only for the granted requester, and only while its reqN_valid = 1 (combinational from the valids and the arbiter state).
REQ-017 SHALL, on a grant, drive sbox_in_valid=1, sbox_in=granted data and sbox_encrypt=granted encrypt in the same cycle; with no grant, it SHALL drive sbox_in_valid=0, sbox_in=8'h00 and sbox_encrypt=1.
REQ-018 SHALL arbitrate round-robin: register last_grant (0/1) updates on every grant; if both requesters are valid, grant the requester != last_grant; if one is valid, grant it.
REQ-019 SHALL carry {valid, id} through a SBOX_LAT-deep tag shift register; a request accepted in cycle t SHALL produce rspID_valid=1 and rspID_data=sbox_out in cycle t+SBOX_LAT.
REQ-020 SHALL sustain one accept per cycle (full throughput); back-to-back grants to the same or alternating requesters SHALL return in order.
REQ-021 SHALL drive rspN_data=8'h00 whenever rspN_valid=0; rsp0_valid and rsp1_valid SHALL never both be 1.
REQ-022 SHALL increment stall_cnt by 1 in any cycle where a valid requester is not granted (both valid -> +1), and hold it at 16'hFFFF once saturated.
REQ-023 SHALL behave identically for SBOX_LAT=1 (a response in the cycle after accept) and SBOX_LAT=8.

Reset
REQ-024 SHALL, while rst=1, clear the tag pipeline, set last_grant=1, set stall_cnt=0, force reqN_ready=0 and sbox_in_valid=0, and drive all rsp outputs to 0.
REQ-025 SHALL drop in-flight results on reset mid-operation: no rsp pulse occurs in the SBOX_LAT cycles after rst deasserts unless that pulse comes from a request accepted after reset.
REQ-026 SHALL grant requester 0 first on contention after reset.

Configuration
REQ-027 SHALL, with macro SBOX_ARB_FIXED_PRIO_EN defined, give requester 1 (key schedule) absolute priority on contention; last_grant is still updated but ignored. Without the macro, it SHALL use round-robin per REQ-018.

Verification
REQ-028 Reset, then req0 valid alone with data 8'h53, encrypt=1 -> req0_ready=1 in the same cycle, sbox_in=8'h53, and rsp0_valid with the bench's sbox_out 8'hED exactly 3 cycles later.
REQ-029 Both valid for 4 cycles -> grants 0,1,0,1; stall_cnt=4; responses alternate rsp0/rsp1 at +3 cycles.
REQ-030 With SBOX_ARB_FIXED_PRIO_EN defined, both valid for 3 cycles -> req1 is granted all 3 cycles; req0 is granted on the 4th cycle when req1 drops.
REQ-031 Launch 2 requests, assert rst for 1 cycle while they are in flight -> no rsp pulses for those 2 requests; stall_cnt=0.
REQ-032 Force stall_cnt to 16'hFFFE with sustained contention -> count reaches 16'hFFFF and holds.
